// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Purpose:
//   Write-side loader for the instruction memory. A byte stream (valid/ready)
//   carries a 16-bit little-endian word count N followed by N {lo, hi} byte
//   pairs. Each pair is packed into a 9-bit instruction {hi[0], lo[7:0]} and
//   written through a sequential write port, starting at BASE_ADDR and
//   wrapping modulo 2**ADDR_W. The core is held off while Busy is high.
//
// Parameters:
//   ADDR_W     address width, memory depth = 2**ADDR_W words (1..15)
//   INSTR_W    instruction width, must be 9
//   BASE_ADDR  first write address of every session
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Start      in   one-cycle pulse, begins a session when not busy
//   ByteIn     in   stream byte
//   ByteValid  in   ByteIn valid
//   ByteReady  out  loader can accept; transfer on ByteValid & ByteReady
//   WrEn       out  memory write strobe, one cycle per instruction
//   WrAddr     out  memory write address
//   WrData     out  memory write data
//   Busy       out  session in progress
//   Done       out  session finished OK, held until next Start
//   Error      out  session aborted, held until next Start
//   Count      out  instructions written this session (saturates at 2**ADDR_W)
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, the session ends with one trailing byte
//                       that must equal the XOR of all instruction-pair bytes;
//                       a mismatch aborts the session with Error.
// -----------------------------------------------------------------------------

module instruction_loader #(
  parameter int ADDR_W    = 12,
  parameter int INSTR_W   = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [7:0]         ByteIn,
  input  logic               ByteValid,
  output logic               ByteReady,
  output logic               WrEn,
  output logic [ADDR_W-1:0]  WrAddr,
  output logic [INSTR_W-1:0] WrData,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [ADDR_W:0]    Count
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR_LO = 4'd1,
    ST_HDR_HI = 4'd2,
    ST_INS_LO = 4'd3,
    ST_INS_HI = 4'd4,
    ST_WRITE  = 4'd5,
    ST_FIN    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

  // Largest legal word count: a session may fill the whole memory once.
  localparam logic [16:0]     MAX_N_C     = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);

  state_t               state_r;
  logic                 ready_r;
  logic                 wr_en_r;
  logic [ADDR_W-1:0]    wr_addr_r;
  logic [INSTR_W-1:0]   wr_data_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 error_r;
  logic [ADDR_W:0]      count_r;
  logic [ADDR_W:0]      n_r;
  logic [7:0]           n_lo_r;
  logic [7:0]           lo_r;

  logic                 xfer_s;
  logic [15:0]          hdr_n_s;
  logic                 hdr_bad_s;
  logic [ADDR_W:0]      count_inc_s;
  logic                 last_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_r;

  // Running XOR fold used as the stream checksum.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Elaboration-time parameter checks.
  instruction_loader_cfg_check #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_cfg_check ();

  assign ByteReady = ready_r;
  assign WrEn      = wr_en_r;
  assign WrAddr    = wr_addr_r;
  assign WrData    = wr_data_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Error     = error_r;
  assign Count     = count_r;

  // Handshake and header decode.
  always_comb begin
    xfer_s    = ByteValid & ready_r;
    hdr_n_s   = {ByteIn, n_lo_r};
    hdr_bad_s = 1'b0;
    if ((hdr_n_s == 16'd0) || ({1'b0, hdr_n_s} > MAX_N_C)) begin
      hdr_bad_s = 1'b1;
    end else begin
      hdr_bad_s = 1'b0;
    end
  end

  // Saturating instruction counter increment and end-of-payload detect.
  always_comb begin
    count_inc_s = count_r;
    if (count_r == COUNT_MAX_C) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
    end
    last_s = (count_inc_s == n_r);
  end

  // Session FSM; all outputs are registered and set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= BASE_C;
      wr_data_r <= {INSTR_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      count_r   <= {(ADDR_W+1){1'b0}};
      n_r       <= {(ADDR_W+1){1'b0}};
      n_lo_r    <= 8'd0;
      lo_r      <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r    <= 8'd0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (Start) begin
            state_r   <= ST_HDR_LO;
            ready_r   <= 1'b1;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            count_r   <= {(ADDR_W+1){1'b0}};
            wr_addr_r <= BASE_C;
`ifdef LOADER_CHECKSUM_EN
            csum_r    <= 8'd0;
`endif
          end
        end
        ST_HDR_LO: begin
          if (xfer_s) begin
            n_lo_r  <= ByteIn;
            state_r <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (xfer_s) begin
            if (hdr_bad_s) begin
              state_r <= ST_ERR;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end else begin
              // N <= 2**ADDR_W, so it fits in ADDR_W+1 bits.
              n_r     <= hdr_n_s[ADDR_W:0];
              state_r <= ST_INS_LO;
            end
          end
        end
        ST_INS_LO: begin
          if (xfer_s) begin
            lo_r    <= ByteIn;
            state_r <= ST_INS_HI;
`ifdef LOADER_CHECKSUM_EN
            csum_r  <= xor_fold(csum_r, ByteIn);
`endif
          end
        end
        ST_INS_HI: begin
          if (xfer_s) begin
`ifdef LOADER_CHECKSUM_EN
            csum_r <= xor_fold(csum_r, ByteIn);
`endif
            if (ByteIn[7:1] != 7'd0) begin
              // Malformed high byte: abort without writing this pair.
              state_r <= ST_ERR;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end else begin
              wr_data_r <= {ByteIn[0], lo_r};
              wr_en_r   <= 1'b1;
              ready_r   <= 1'b0;
              state_r   <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // WrEn is high during this cycle; advance address after it.
          wr_addr_r <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          count_r   <= count_inc_s;
          if (last_s) begin
            state_r <= ST_FIN;
`ifdef LOADER_CHECKSUM_EN
            ready_r <= 1'b1;
`else
            ready_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_INS_LO;
            ready_r <= 1'b1;
          end
        end
        ST_FIN: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer_s) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            if (ByteIn == csum_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end
`else
          state_r <= ST_DONE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
`endif
        end
        default: begin
          // Unreachable encoding: park safely in the error state.
          state_r <= ST_ERR;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          error_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// -----------------------------------------------------------------------------
// instruction_loader_cfg_check
//
// Purpose:
//   Elaboration-time checks of the loader parameters. No ports.
// -----------------------------------------------------------------------------
module instruction_loader_cfg_check #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 9
) ();

  if (INSTR_W != 9) begin : g_bad_instr_w
    $error("instruction_loader: INSTR_W must be 9");
  end

  if ((ADDR_W < 1) || (ADDR_W > 15)) begin : g_bad_addr_w
    $error("instruction_loader: ADDR_W must be in 1..15");
  end

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//
// Drives two loader instances (BASE_ADDR 0 and 4090) from the same byte
// stream and compares their write ports and status against a stream-level
// reference model that parses the byte list directly.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int BASE_B = 4090;

  typedef logic [20:0] wr_t;  // {addr[11:0], data[8:0]}

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;

  logic        ready_a, wr_en_a, busy_a, done_a, error_a;
  logic [11:0] wr_addr_a;
  logic [8:0]  wr_data_a;
  logic [12:0] count_a;
  logic        ready_b, wr_en_b, busy_b, done_b, error_b;
  logic [11:0] wr_addr_b;
  logic [8:0]  wr_data_b;
  logic [12:0] count_b;

  int checks   = 0;
  int failures = 0;

  wr_t        act_a[$];
  wr_t        act_b[$];
  wr_t        exp_a[$];
  wr_t        exp_b[$];
  logic [7:0] stream_q[$];
  bit         exp_done;
  bit         exp_err;
  int         exp_count;
  int         exp_consumed;

  instruction_loader #(.ADDR_W(ADDR_W), .INSTR_W(9), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready_a), .WrEn(wr_en_a), .WrAddr(wr_addr_a), .WrData(wr_data_a),
    .Busy(busy_a), .Done(done_a), .Error(error_a), .Count(count_a)
  );

  instruction_loader #(.ADDR_W(ADDR_W), .INSTR_W(9), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready_b), .WrEn(wr_en_b), .WrAddr(wr_addr_b), .WrData(wr_data_b),
    .Busy(busy_b), .Done(done_b), .Error(error_b), .Count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en_a) act_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) act_b.push_back({wr_addr_b, wr_data_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_hdr(input int n);
    stream_q.push_back(8'(n & 255));
    stream_q.push_back(8'((n >> 8) & 255));
  endtask

  task automatic add_pair(input logic [7:0] lo, input logic [7:0] hi);
    stream_q.push_back(lo);
    stream_q.push_back(hi);
  endtask

  task automatic add_rand_pairs(input int k);
    for (int i = 0; i < k; i++) add_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 1)));
  endtask

  task automatic add_csum(input bit good);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 2; i < stream_q.size(); i++) x ^= stream_q[i];
    stream_q.push_back(good ? x : (x ^ 8'h01));
  endtask

  // Reference model: parse the byte list and list the writes it implies.
  task automatic model_run();
    int n;
    logic [7:0]  lo, hi, x;
    logic [11:0] aa, ab;
    exp_a.delete();
    exp_b.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_count = 0;
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      exp_consumed = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      lo = stream_q[2 + 2 * i];
      hi = stream_q[3 + 2 * i];
      if (hi > 8'd1) begin
        exp_err = 1'b1;
        exp_consumed = 4 + 2 * i;
        return;
      end
      aa = 12'(i % DEPTH);
      ab = 12'((BASE_B + i) % DEPTH);
      exp_a.push_back({aa, hi[0], lo});
      exp_b.push_back({ab, hi[0], lo});
      exp_count++;
    end
    exp_consumed = 2 + 2 * n;
`ifdef LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int i = 2; i < 2 + 2 * n; i++) x ^= stream_q[i];
    exp_consumed++;
    if (stream_q[2 + 2 * n] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    x = 8'd0;
    exp_done = 1'b1;
`endif
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit r;
    int waited;
    ByteIn    = b;
    ByteValid = 1'b1;
    waited    = 0;
    ok        = 1'b1;
    forever begin
      @(negedge clk);
      r = ready_a;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 200) begin
        ok = 1'b0;
        break;
      end
    end
    ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic run_session(input string tag, input bit gaps, input bit start_mid);
    bit ok;
    int waited;
    model_run();
    step();
    act_a.delete();
    act_b.delete();
    pulse_start();
    @(negedge clk);
    check({tag, "_start_busy"},  busy_a,  1);
    check({tag, "_start_done"},  done_a,  0);
    check({tag, "_start_err"},   error_a, 0);
    check({tag, "_start_count"}, count_a, 0);
    step();
    for (int k = 0; k < exp_consumed; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step();
      if (start_mid && k == 2) pulse_start();
      send_byte(stream_q[k], ok);
      if (!ok) begin
        check({tag, "_byte_accept_timeout"}, k, 32'hFFFF_FFFF);
        break;
      end
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if (done_a || error_a || waited > 60) break;
      waited++;
    end
    check({tag, "_finish_seen"}, done_a | error_a, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done"},   done_a,  exp_done);
    check({tag, "_err"},    error_a, exp_err);
    check({tag, "_busy"},   busy_a,  0);
    check({tag, "_ready"},  ready_a, 0);
    check({tag, "_count"},  count_a, exp_count);
    check({tag, "_addr"},   wr_addr_a, exp_count % DEPTH);
    check({tag, "_b_done"}, done_b,  exp_done);
    check({tag, "_b_count"}, count_b, exp_count);
    check({tag, "_b_addr"}, wr_addr_b, (BASE_B + exp_count) % DEPTH);
    check({tag, "_nwrites"},   act_a.size(), exp_a.size());
    check({tag, "_b_nwrites"}, act_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      check({tag, "_wr"}, act_a[i], exp_a[i]);
      if (act_a[i] !== exp_a[i]) break;
    end
    for (int i = 0; i < exp_b.size() && i < act_b.size(); i++) begin
      check({tag, "_b_wr"}, act_b[i], exp_b[i]);
      if (act_b[i] !== exp_b[i]) break;
    end
  endtask

  task automatic load_test1();
    stream_q.delete();
    add_hdr(2);
    add_pair(8'h5A, 8'h01);
    add_pair(8'hFF, 8'h00);
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    Start     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", ready_a, 0);
    check("rst_wren",  wr_en_a, 0);
    check("rst_busy",  busy_a,  0);
    check("rst_done",  done_a,  0);
    check("rst_err",   error_a, 0);
    check("rst_addr",  wr_addr_a, 0);
    check("rst_b_addr", wr_addr_b, BASE_B);
    check("rst_data",  wr_data_a, 0);
    check("rst_count", count_a, 0);
    step();
    rst_n = 1'b1;

    // Bytes offered while idle are ignored.
    ByteIn = 8'h77;
    ByteValid = 1'b1;
    repeat (5) step();
    ByteValid = 1'b0;
    @(negedge clk);
    check("idle_no_writes", act_a.size(), 0);
    check("idle_busy", busy_a, 0);
    check("idle_ready", ready_a, 0);

    // Basic two-instruction load, then the same with gapped valid.
    load_test1();
`ifdef LOADER_CHECKSUM_EN
    add_csum(1'b1);
`endif
    run_session("t1", 1'b0, 1'b0);
    check("t1_wr0_lit", act_a[0], {12'd0, 9'h15A});
    check("t1_wr1_lit", act_a[1], {12'd1, 9'h0FF});
    check("t1_b_wr0_lit", act_b[0], {12'd4090, 9'h15A});
    check("t1_count_lit", count_a, 2);
    run_session("t2_gaps", 1'b1, 1'b0);

    // Bad headers.
    stream_q.delete();
    add_hdr(0);
    run_session("t3_n0", 1'b1, 1'b0);
    check("t3_n0_nowr", act_a.size(), 0);
    stream_q.delete();
    add_hdr(4097);
    run_session("t3_n4097", 1'b0, 1'b0);
    check("t3_n4097_err", error_a, 1);

    // Malformed high byte in the third pair.
    stream_q.delete();
    add_hdr(3);
    add_rand_pairs(2);
    add_pair(8'h33, 8'h02);
    run_session("t4_badhi", 1'b1, 1'b0);
    check("t4_err", error_a, 1);
    check("t4_nwr", act_a.size(), 2);

    // Random sessions, one with a Start pulse while busy.
    for (int s = 0; s < 6; s++) begin
      stream_q.delete();
      add_hdr($urandom_range(1, 40));
      add_rand_pairs(int'(stream_q[0]));
      if (s == 4) stream_q[5] = 8'h80;
`ifdef LOADER_CHECKSUM_EN
      add_csum(1'b1);
`endif
      run_session($sformatf("rnd%0d", s), 1'b1, s == 2);
    end

    // Full-memory load: wraps the address of the offset instance.
    stream_q.delete();
    add_hdr(DEPTH);
    add_rand_pairs(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    add_csum(1'b1);
`endif
    run_session("t5_full", 1'b0, 1'b0);
    check("t5_count", count_a, 4096);
    check("t5_b_wrap", act_b[6], {12'd0, exp_b[6][8:0]});

`ifdef LOADER_CHECKSUM_EN
    load_test1();
    add_csum(1'b0);
    run_session("t7_badsum", 1'b0, 1'b0);
    check("t7_err", error_a, 1);
`endif

    // Asynchronous reset while waiting for a high byte.
    step();
    pulse_start();
    send_byte(8'h05, ok);
    send_byte(8'h00, ok);
    send_byte(8'h12, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ready", ready_a, 0);
    check("t6_wren",  wr_en_a, 0);
    check("t6_busy",  busy_a,  0);
    check("t6_done",  done_a,  0);
    check("t6_err",   error_a, 0);
    check("t6_addr",  wr_addr_a, 0);
    check("t6_b_addr", wr_addr_b, BASE_B);
    check("t6_data",  wr_data_a, 0);
    check("t6_count", count_a, 0);
    step();
    rst_n = 1'b1;

    load_test1();
`ifdef LOADER_CHECKSUM_EN
    add_csum(1'b1);
`endif
    run_session("t6_after", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
